// File: rtl/seg7_pkg.sv
// Shared constants, display payload type and nibble selection for the seven-segment scanner.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned DIGIT_IDX_W = 2;
    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned VALUE_W     = NUM_DIGITS * NIBBLE_W;

    // One full display image: four hex nibbles plus one decimal point per digit.
    typedef struct packed {
        logic [VALUE_W-1:0]    value;
        logic [NUM_DIGITS-1:0] dots;
    } disp_frame_t;

    // Nibble belonging to digit idx, digit 0 in the least significant position.
    function automatic logic [NIBBLE_W-1:0] nibble_sel(
        input logic [VALUE_W-1:0]     value,
        input logic [DIGIT_IDX_W-1:0] idx
    );
        logic [VALUE_W-1:0] shifted;
        shifted = value >> (NIBBLE_W * 32'(idx));
        return shifted[NIBBLE_W-1:0];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Refresh prescaler: counts enabled cycles and flags the last cycle of each DIV-cycle period.
module tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    output logic TICK_OUT
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Tick is combinational so the digit advances on the same edge that wraps the counter.
    assign TICK_OUT = ENABLE && (cnt == LAST);

    // Counter holds while disabled and wraps to zero on tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (TICK_OUT) begin
            cnt <= '0;
        end else if (ENABLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_mux.sv
// Four-digit time-multiplexed display scanner with frame-synchronous (tear-free) updates.
module seg7_mux
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic                   LOAD,
    input  logic [VALUE_W-1:0]     VALUE_IN,
    input  logic [NUM_DIGITS-1:0]  DOTS_IN,
    output logic [DIGIT_IDX_W-1:0] SEG_SELECT_OUT,
    output logic [NIBBLE_W-1:0]    BIN_OUT,
    output logic                   DOT_OUT,
    output logic                   FRAME_OUT
);

    localparam logic [DIGIT_IDX_W-1:0] LAST_DIGIT = DIGIT_IDX_W'(NUM_DIGITS - 1);

    logic                   tick;
    logic                   boundary;
    logic [DIGIT_IDX_W-1:0] digit_q, digit_d;
    logic                   pending, pending_d;
    disp_frame_t            pend_q, pend_d;
    disp_frame_t            disp_q, disp_d;
    disp_frame_t            incoming;

    tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .TICK_OUT (tick)
    );

    assign incoming = {VALUE_IN, DOTS_IN};
    assign boundary = tick && (digit_q == LAST_DIGIT);

    // Next digit and double-buffer update; display image only changes at a frame boundary.
    always_comb begin
        digit_d   = digit_q;
        pending_d = pending;
        pend_d    = pend_q;
        disp_d    = disp_q;
        if (tick) begin
            digit_d = digit_q + DIGIT_IDX_W'(1);
        end
        if (boundary) begin
            if (LOAD) begin
                disp_d = incoming;
            end else if (pending) begin
                disp_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (LOAD) begin
            pend_d    = incoming;
            pending_d = 1'b1;
        end
    end

    // State and output registers; outputs are precomputed from next state so they track digit_q.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            digit_q   <= '0;
            pending   <= 1'b0;
            pend_q    <= '0;
            disp_q    <= '0;
            BIN_OUT   <= '0;
            DOT_OUT   <= 1'b0;
            FRAME_OUT <= 1'b0;
        end else begin
            digit_q   <= digit_d;
            pending   <= pending_d;
            pend_q    <= pend_d;
            disp_q    <= disp_d;
            BIN_OUT   <= nibble_sel(disp_d.value, digit_d);
            DOT_OUT   <= disp_d.dots[digit_d];
            FRAME_OUT <= boundary;
        end
    end

    assign SEG_SELECT_OUT = digit_q;

endmodule

// File: tb/tb_seg7_mux.sv
// Randomised and directed bench for seg7_mux against a cycle-count based reference model.
module tb_seg7_mux;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] VALUE_IN = '0;
    logic [3:0]  DOTS_IN = '0;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;
    logic        DOT_OUT;
    logic        FRAME_OUT;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: number of enabled cycles since reset determines position in the scan.
    int          m_t;
    logic [15:0] m_disp;
    logic [3:0]  m_dots;
    logic        m_pend;
    logic [15:0] m_pv;
    logic [3:0]  m_pd;
    logic        m_frame;

    seg7_mux #(
        .REFRESH_DIV (DIV)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .LOAD           (LOAD),
        .VALUE_IN       (VALUE_IN),
        .DOTS_IN        (DOTS_IN),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .BIN_OUT        (BIN_OUT),
        .DOT_OUT        (DOT_OUT),
        .FRAME_OUT      (FRAME_OUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] exp_sel();
        return 2'((m_t / DIV) % 4);
    endfunction

    function automatic logic [3:0] exp_bin();
        logic [15:0] s;
        s = m_disp >> (4 * int'(exp_sel()));
        return s[3:0];
    endfunction

    function automatic logic exp_dot();
        return m_dots[exp_sel()];
    endfunction

    task automatic model_reset();
        m_t = 0; m_disp = '0; m_dots = '0; m_pend = 1'b0;
        m_pv = '0; m_pd = '0; m_frame = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model, leave the bench 1 time unit past the edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic en);
        logic bnd;
        LOAD = ld; VALUE_IN = v; DOTS_IN = d; ENABLE = en;
        @(posedge CLK);
        bnd = en && ((m_t % FRAME) == FRAME - 1);
        if (bnd) begin
            if (ld) begin
                m_disp = v; m_dots = d;
            end else if (m_pend) begin
                m_disp = m_pv; m_dots = m_pd;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pv = v; m_pd = d; m_pend = 1'b1;
        end
        if (en) m_t++;
        m_frame = bnd;
        #1;
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        // Outputs during reset, then async assertion mid-scan with a load pending.
        repeat (2) @(posedge CLK);
        #1;
        n_vec++; if ({SEG_SELECT_OUT, BIN_OUT, DOT_OUT, FRAME_OUT} !== 8'h00) begin
            n_err++; $display("FAIL reset_hold outputs got %h want 00", {SEG_SELECT_OUT, BIN_OUT, DOT_OUT, FRAME_OUT});
        end
        RESET = 1'b0;
        model_reset();
        step(1'b1, 16'h1234, 4'hF, 1'b1);
        for (int i = 0; i < 21; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b1, 16'h9876, 4'hA, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
        n_vec++; if (SEG_SELECT_OUT !== exp_sel() || BIN_OUT !== exp_bin()) begin
            n_err++; $display("FAIL reset_prescan sel/bin got %0d/%h want %0d/%h", SEG_SELECT_OUT, BIN_OUT, exp_sel(), exp_bin());
        end
        RESET = 1'b1;
        #2;
        n_vec++; if ({SEG_SELECT_OUT, BIN_OUT, DOT_OUT, FRAME_OUT} !== 8'h00) begin
            n_err++; $display("FAIL reset_async outputs got %h want 00", {SEG_SELECT_OUT, BIN_OUT, DOT_OUT, FRAME_OUT});
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b1);
            n_vec++; if (SEG_SELECT_OUT !== 2'((m_t / DIV) % 4)) begin
                n_err++; $display("FAIL reset_after sel got %0d want %0d", SEG_SELECT_OUT, exp_sel());
            end
            n_vec++; if (BIN_OUT !== 4'h0 || DOT_OUT !== 1'b0) begin
                n_err++; $display("FAIL reset_after bin/dot got %h/%b want 0/0", BIN_OUT, DOT_OUT);
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [15:0] ref_val = 16'hA5C3;
        logic [3:0]  ref_dot = 4'b0101;
        int          seen = -1;
        while ((m_t % FRAME) != 6) step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b1, ref_val, ref_dot, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'hFFFF, 4'hF, 1'b1);
            if (FRAME_OUT === 1'b1 && seen < 0) seen = 0;
            else if (seen >= 0) seen++;
            n_vec++; if (SEG_SELECT_OUT !== exp_sel() || BIN_OUT !== exp_bin() || DOT_OUT !== exp_dot()) begin
                n_err++; $display("FAIL midframe got %0d/%h/%b want %0d/%h/%b", SEG_SELECT_OUT, BIN_OUT, DOT_OUT, exp_sel(), exp_bin(), exp_dot());
            end
            if (seen >= 0 && seen < FRAME) begin
                n_vec++; if (BIN_OUT !== 4'((ref_val >> (4 * (seen / DIV))) & 16'hF) || DOT_OUT !== ref_dot[seen / DIV]
                             || SEG_SELECT_OUT !== 2'(seen / DIV)) begin
                    n_err++; $display("FAIL midframe_seq pos %0d got %0d/%h/%b", seen, SEG_SELECT_OUT, BIN_OUT, DOT_OUT);
                end
            end
            n_vec++; if (FRAME_OUT !== m_frame) begin
                n_err++; $display("FAIL midframe frame got %b want %b", FRAME_OUT, m_frame);
            end
        end
    endtask

    task automatic test_last_write_wins();
        while ((m_t % FRAME) != 2) step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b1, 16'h1111, 4'h3, 1'b1);
        step(1'b1, 16'h2222, 4'h0, 1'b1);
        for (int i = 0; i < FRAME + 14; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b1);
            n_vec++; if (BIN_OUT !== exp_bin() || DOT_OUT !== exp_dot()) begin
                n_err++; $display("FAIL last_write bin/dot got %h/%b want %h/%b", BIN_OUT, DOT_OUT, exp_bin(), exp_dot());
            end
        end
        n_vec++; if (m_disp !== 16'h2222 || BIN_OUT !== 4'h2) begin
            n_err++; $display("FAIL last_write final bin got %h want 2", BIN_OUT);
        end
    endtask

    task automatic test_boundary_load();
        while ((m_t % FRAME) != FRAME - 1) step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b1, 16'hBEEF, 4'h0, 1'b1);
        n_vec++; if (FRAME_OUT !== 1'b1 || BIN_OUT !== 4'hF) begin
            n_err++; $display("FAIL boundary_load frame/bin got %b/%h want 1/f", FRAME_OUT, BIN_OUT);
        end
        n_vec++; if (dut.pending !== 1'b0) begin
            n_err++; $display("FAIL boundary_pending got %b want 0", dut.pending);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b1);
            n_vec++; if (SEG_SELECT_OUT !== exp_sel() || BIN_OUT !== exp_bin() || FRAME_OUT !== m_frame) begin
                n_err++; $display("FAIL boundary_follow got %0d/%h/%b want %0d/%h/%b", SEG_SELECT_OUT, BIN_OUT, FRAME_OUT, exp_sel(), exp_bin(), m_frame);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [3:0] held;
        while ((m_t % FRAME) != 2 * DIV + 1) step(1'b0, 16'h0, 4'h0, 1'b1);
        held = BIN_OUT;
        for (int i = 0; i < 10; i++) begin
            step(i == 4, 16'h7777, 4'hF, 1'b0);
            n_vec++; if (SEG_SELECT_OUT !== 2'd2 || FRAME_OUT !== 1'b0 || BIN_OUT !== held) begin
                n_err++; $display("FAIL enable_hold got %0d/%b/%h want 2/0/%h", SEG_SELECT_OUT, FRAME_OUT, BIN_OUT, held);
            end
        end
        for (int i = 0; i < FRAME + 8; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b1);
            n_vec++; if (SEG_SELECT_OUT !== exp_sel() || BIN_OUT !== exp_bin() || DOT_OUT !== exp_dot() || FRAME_OUT !== m_frame) begin
                n_err++; $display("FAIL enable_resume got %0d/%h/%b/%b want %0d/%h/%b/%b", SEG_SELECT_OUT, BIN_OUT, DOT_OUT, FRAME_OUT, exp_sel(), exp_bin(), exp_dot(), m_frame);
            end
        end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        int last = -1;
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b1);
            if (FRAME_OUT === 1'b1) begin
                if (last >= 0) begin
                    n_vec++; if (i - last != FRAME) begin
                        n_err++; $display("FAIL free_run spacing got %0d want %0d", i - last, FRAME);
                    end
                end
                last = i;
                pulses++;
            end
        end
        n_vec++; if (pulses != 4) begin
            n_err++; $display("FAIL free_run pulses got %0d want 4", pulses);
        end
    endtask

    task automatic test_random();
        logic ld, en;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 5) == 0);
            en = ($urandom_range(0, 7) != 0);
            step(ld, 16'($urandom), 4'($urandom), en);
            n_vec++; if (SEG_SELECT_OUT !== exp_sel() || BIN_OUT !== exp_bin() || DOT_OUT !== exp_dot() || FRAME_OUT !== m_frame) begin
                n_err++; $display("FAIL random cyc %0d got %0d/%h/%b/%b want %0d/%h/%b/%b", i, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, FRAME_OUT, exp_sel(), exp_bin(), exp_dot(), m_frame);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_midframe();
        test_last_write_wins();
        test_boundary_load();
        test_enable_hold();
        test_free_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
